// File: rtl/deser_frame_align.sv
// deser_frame_align: frame-clock driven bit-slip word alignment behind a 1:S LVDS deserializer
module deser_frame_align #(
  parameter int S = 7,
  parameter int D = 2,
  parameter logic [S-1:0] FRAME_PATTERN = 7'b1100011,
  parameter int LOCK_CNT = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [S-1:0]     clk_data,
  input  logic [S*D-1:0]   rx_data,
  input  logic             err_clr,
  output logic [S*D-1:0]   aligned_data,
  output logic             data_valid,
  output logic [S-1:0]     sig,
  output logic [S-1:0]     mag,
  output logic             locked,
  output logic [2:0]       slip_pos,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int NW = $clog2(UNLOCK_CNT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [NW-1:0] MISS_LAST = NW'(UNLOCK_CNT - 1);
  localparam logic [2:0] SLIP_LAST = 3'(S - 1);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  state_t state, state_n;
  logic [S-1:0] q1_clk, q2_clk, cw;
  logic [S*D-1:0] q1_rx, q2_rx, rot_data;
  logic match, err_inc;
  logic [2:0] slip_n, slip_adv;
  logic [MW-1:0] match_cnt, match_n;
  logic [NW-1:0] miss_cnt, miss_n;
  logic [ERR_W-1:0] err_n;
  // window {newer, older}; candidate k takes S bits starting at bit k, so k=0 is the older word
  function automatic logic [S-1:0] rot(input logic [2*S-1:0] w, input logic [2:0] k);
    for (int i = 0; i < S; i++) rot[i] = w[i + int'(k)];
  endfunction
  assign cw = rot({q1_clk, q2_clk}, slip_pos);
  assign match = cw == FRAME_PATTERN;
  assign slip_adv = (slip_pos == SLIP_LAST) ? 3'd0 : slip_pos + 3'd1;
  for (genvar j = 0; j < D; j++) begin : g_line
    assign rot_data[j*S +: S] = rot({q1_rx[j*S +: S], q2_rx[j*S +: S]}, slip_pos);
  end
  assign sig = aligned_data[S-1:0];
  assign mag = aligned_data[2*S-1:S];
  // two-word input history feeding the rotation window
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q1_clk <= '0;
      q2_clk <= '0;
      q1_rx <= '0;
      q2_rx <= '0;
    end else begin
      q1_clk <= clk_data;
      q2_clk <= q1_clk;
      q1_rx <= rx_data;
      q2_rx <= q1_rx;
    end
  // search / verify / locked decisions with match and miss hysteresis
  always_comb begin
    state_n = state;
    slip_n = slip_pos;
    match_n = match_cnt;
    miss_n = miss_cnt;
    err_inc = 1'b0;
    if (!enable) begin
      state_n = SEARCH;
      slip_n = 3'd0;
      match_n = '0;
      miss_n = '0;
    end else begin
      case (state)
        SEARCH: begin
          state_n = match ? ((LOCK_CNT == 1) ? LOCKED : VERIFY) : SEARCH;
          match_n = match ? MW'(1) : '0;
          slip_n = match ? slip_pos : slip_adv;
        end
        VERIFY: begin
          state_n = !match ? SEARCH : (match_cnt == MATCH_LAST) ? LOCKED : VERIFY;
          match_n = match ? match_cnt + 1'b1 : '0;
          slip_n = match ? slip_pos : slip_adv;
        end
        LOCKED: begin
          err_inc = !match;
          state_n = (!match && miss_cnt == MISS_LAST) ? SEARCH : LOCKED;
          miss_n = (match || miss_cnt == MISS_LAST) ? '0 : miss_cnt + 1'b1;
        end
        default: state_n = SEARCH;
      endcase
    end
    err_n = err_clr ? '0 : (err_inc && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
  end
  // alignment state and counters
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= SEARCH;
      slip_pos <= 3'd0;
      match_cnt <= '0;
      miss_cnt <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      slip_pos <= slip_n;
      match_cnt <= match_n;
      miss_cnt <= miss_n;
      err_cnt <= err_n;
    end
  // lock flag tracks the next state so it lines up with the word aligned this cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      aligned_data <= '0;
      locked <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      aligned_data <= rot_data;
      locked <= state_n == LOCKED;
      data_valid <= state_n == LOCKED;
    end
endmodule

// File: tb/tb_deser_frame_align.sv
// tb_deser_frame_align: randomized stimulus against a word-level reference model of deser_frame_align
module tb_deser_frame_align;
  localparam int S = 7;
  localparam int PAT = 7'b1100011;
  localparam int LOCK_N = 16;
  localparam int UNLOCK_N = 4;
  localparam int ERR_MAX = 15;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [6:0] clk_data = '0;
  logic [13:0] rx_data = '0;
  logic err_clr = 1'b0;
  logic [13:0] aligned_data;
  logic data_valid, locked;
  logic [6:0] sig, mag;
  logic [2:0] slip_pos;
  logic [3:0] err_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int h1c, h2c, mstate, mslip, mmatch, mmiss, merr, exp_ad, exp_lk;
  int h1r[2], h2r[2];
  deser_frame_align #(.ERR_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clk_data(clk_data), .rx_data(rx_data),
    .err_clr(err_clr), .aligned_data(aligned_data), .data_valid(data_valid), .sig(sig),
    .mag(mag), .locked(locked), .slip_pos(slip_pos), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int rotw(input int newer, input int older, input int k);
    return (((newer << S) | older) >> k) & 127;
  endfunction
  function automatic int rotl(input int x, input int r);
    return ((x << r) | (x >> (S - r))) & 127;
  endfunction
  task automatic model_reset();
    h1c = 0; h2c = 0; h1r = '{0, 0}; h2r = '{0, 0};
    mstate = 0; mslip = 0; mmatch = 0; mmiss = 0; merr = 0; exp_ad = 0; exp_lk = 0;
  endtask
  // 0 = searching, 1 = verifying, 2 = locked; counts compared with plain integers
  task automatic model_step();
    int ns, nsl, nm, nmi;
    bit m, inc;
    m = rotw(h1c, h2c, mslip) == PAT;
    ns = mstate; nsl = mslip; nm = mmatch; nmi = mmiss; inc = 0;
    if (!enable) begin
      ns = 0; nsl = 0; nm = 0; nmi = 0;
    end else if (mstate == 0) begin
      if (m) begin ns = (LOCK_N == 1) ? 2 : 1; nm = 1; end
      else nsl = (mslip + 1) % S;
    end else if (mstate == 1) begin
      if (m) begin nm = mmatch + 1; if (nm >= LOCK_N) ns = 2; end
      else begin ns = 0; nm = 0; nsl = (mslip + 1) % S; end
    end else if (m) nmi = 0;
    else begin
      inc = 1; nmi = mmiss + 1;
      if (nmi >= UNLOCK_N) begin ns = 0; nmi = 0; end
    end
    if (err_clr) merr = 0;
    else if (inc && merr < ERR_MAX) merr = merr + 1;
    exp_ad = (rotw(h1r[1], h2r[1], mslip) << S) | rotw(h1r[0], h2r[0], mslip);
    exp_lk = (ns == 2);
    mstate = ns; mslip = nsl; mmatch = nm; mmiss = nmi;
    h2c = h1c; h1c = int'(clk_data);
    for (int j = 0; j < 2; j++) begin
      h2r[j] = h1r[j];
      h1r[j] = int'(rx_data >> (S * j)) & 127;
    end
  endtask
  task automatic cyc(input int c, input int r, input bit en, input bit clr);
    clk_data = 7'(c); rx_data = 14'(r); enable = en; err_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    check("aligned", aligned_data, exp_ad);
    check("locked", locked, exp_lk);
    check("valid", data_valid, exp_lk);
    check("slip", slip_pos, mslip);
    check("err", err_cnt, merr);
    check("sig", sig, exp_ad & 127);
    check("mag", mag, exp_ad >> S);
  endtask
  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; err_clr = 1'b0;
    model_reset();
    #1;
    check("rst_aligned", aligned_data, 0);
    check("rst_locked", locked, 0);
    check("rst_valid", data_valid, 0);
    check("rst_slip", slip_pos, 0);
    check("rst_err", err_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic good(input int n, input int r);
    for (int i = 0; i < n; i++) cyc(rotl(PAT, r), $urandom_range(0, 16383), 1, 0);
  endtask
  task automatic bad(input int n, input int r);
    for (int i = 0; i < n; i++) cyc(rotl(PAT, r) ^ $urandom_range(1, 127), $urandom_range(0, 16383), 1, 0);
  endtask
  initial begin
    int a, b, rr;
    @(posedge clk);
    #1;
    do_reset();
    // aligned frame clock, constant data
    repeat (3) cyc(PAT, 14'h1555, 0, 0);
    repeat (15) cyc(PAT, 14'h1555, 1, 0);
    check("t1_not_yet", locked, 0);
    cyc(PAT, 14'h1555, 1, 0);
    check("t1_locked", locked, 1);
    check("t1_slip", slip_pos, 0);
    check("t1_aligned", aligned_data, 14'h1555);
    check("t1_sig", sig, 7'h55);
    check("t1_mag", mag, 7'h2A);
    // tolerated errors, then lock loss, then saturation and clear
    bad(3, 0);
    good(3, 0);
    check("t3_err3", err_cnt, 3);
    check("t3_still_locked", locked, 1);
    bad(4, 0);
    good(2, 0);
    check("t3_err7", err_cnt, 7);
    check("t3_unlocked", locked, 0);
    for (int k = 0; k < 3; k++) begin
      good(20, 0);
      bad(4, 0);
      good(2, 0);
    end
    check("t5_saturated", err_cnt, 15);
    good(20, 0);
    bad(1, 0);
    good(1, 0);
    cyc(PAT, 0, 1, 1);
    check("t5_clr", err_cnt, 0);
    // frame clock rotated by 3, data lines rotated alike
    do_reset();
    a = $urandom_range(0, 127); b = $urandom_range(0, 127);
    repeat (3) cyc(rotl(PAT, 3), (rotl(b, 3) << S) | rotl(a, 3), 0, 0);
    repeat (19) cyc(rotl(PAT, 3), (rotl(b, 3) << S) | rotl(a, 3), 1, 0);
    check("t2_locked", locked, 1);
    check("t2_slip", slip_pos, 3);
    check("t2_aligned", aligned_data, (b << S) | a);
    cyc(rotl(PAT, 3), 0, 0, 0);
    check("t6_en_unlock", locked, 0);
    check("t6_en_slip", slip_pos, 0);
    // one bad word during verification restarts the search
    do_reset();
    repeat (3) cyc(PAT, $urandom_range(0, 16383), 0, 0);
    good(10, 0);
    bad(1, 0);
    good(2, 0);
    check("t4_slip_adv", slip_pos, 1);
    check("t4_unlocked", locked, 0);
    good(10, 0);
    check("t4_no_early_lock", locked, 0);
    do_reset();
    // random segments: rotations, sporadic corruption, enable drops, clears
    for (int seg = 0; seg < 6; seg++) begin
      rr = $urandom_range(0, 6);
      for (int i = 0; i < 80; i++)
        cyc(($urandom_range(0, 19) == 0) ? rotl(PAT, rr) ^ $urandom_range(1, 127) : rotl(PAT, rr),
            $urandom_range(0, 16383), $urandom_range(0, 59) != 0, $urandom_range(0, 49) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
